alarm12: RTL

- 12-hour alarm unit. Reads the running time from the timekeeping core (cur_isPM/cur_hours/cur_minutes) and stores an alarm time written by the setter path through the same load-pulse interface (load strobe plus isPM/hours/minutes) that the setter uses to write the clock.
- Compares stored and running time. Rings on a match. Supports snooze, dismiss and auto-timeout, counted in 1 Hz ticks.
- Sits beside the clock core in the top level. Its outputs feed the display mux and a buzzer/LED.

---
 rtl/alarm12.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alarm12.sv
// alarm12: 12-hour alarm with ring, snooze, dismiss and auto-timeout.
// Ports: clk/reset/tick, cur_* running time, enable, alarm_load+in_* load,
//   dismiss/snooze pulses; ringing/snoozing/state, alarm_* stored time.
module alarm12 #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cur_isPM,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic       enable,
  input  logic       alarm_load,
  input  logic       in_isPM,
  input  logic [4:0] in_hours,
  input  logic [5:0] in_minutes,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       ringing,
  output logic       snoozing,
  output logic       alarm_isPM,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  // Terminal counts: exit fires on the tick that reaches the limit.
  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECONDS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       match_dly_q;
  logic       al_pm_q, al_pm_d;
  logic [4:0] al_hr_q, al_hr_d;
  logic [5:0] al_min_q, al_min_d;

  logic match;
  logic load_ok;
  logic match_rise;

  assign match = (cur_isPM == al_pm_q) &&
                 (cur_hours == al_hr_q) &&
                 (cur_minutes == al_min_q);

  assign load_ok = alarm_load &&
                   (in_hours >= 5'd1) &&
                   (in_hours <= 5'd12) &&
                   (in_minutes <= 6'd59);

  assign match_rise = match && !match_dly_q;

  always_comb begin
    al_pm_d  = al_pm_q;
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (load_ok) begin
      al_pm_d  = in_isPM;
      al_hr_d  = in_hours;
      al_min_d = in_minutes;
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!enable || load_ok) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match_rise) begin
            state_d    = S_RING;
            ring_cnt_d = 8'd0;
          end
        end
        S_RING: begin
          if (dismiss) begin
            state_d = S_IDLE;
          end else if (snooze) begin
            state_d   = S_SNZ;
            snz_cnt_d = 10'd0;
          end else if (tick) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            if (ring_cnt_q == RING_LAST) begin
              state_d = S_IDLE;
            end
          end
        end
        S_SNZ: begin
          if (dismiss) begin
            state_d = S_IDLE;
          end else if (tick) begin
            snz_cnt_d = snz_cnt_q + 10'd1;
            if (snz_cnt_q == SNZ_LAST) begin
              state_d    = S_RING;
              ring_cnt_d = 8'd0;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ring_cnt_q  <= 8'd0;
      snz_cnt_q   <= 10'd0;
      match_dly_q <= 1'b0;
      al_pm_q     <= 1'b0;
      al_hr_q     <= 5'd12;
      al_min_q    <= 6'd0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      match_dly_q <= match;
      al_pm_q     <= al_pm_d;
      al_hr_q     <= al_hr_d;
      al_min_q    <= al_min_d;
    end
  end

  assign ringing       = (state_q == S_RING);
  assign snoozing      = (state_q == S_SNZ);
  assign state         = state_q;
  assign alarm_isPM    = al_pm_q;
  assign alarm_hours   = al_hr_q;
  assign alarm_minutes = al_min_q;

endmodule
